// File: rtl/hazard_ctrl.sv
`default_nettype none
// hazard_ctrl: decode-stage hazard controller (EX/MEM/WB scoreboard, forwarding, stall, flush FSM).
// Optional stall counter output enabled by defining HAZARD_STATS_EN.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned REG_AW       = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_freeze,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  input  logic              i_id_use_rs,
  input  logic              i_id_use_rt,
  input  logic [REG_AW-1:0] i_id_wr_addr,
  input  logic              i_id_reg_write,
  input  logic              i_id_mem_read,
  input  logic              i_exception,
  input  logic              i_eret,
  output logic [1:0]        o_mux_ctrl1,
  output logic [1:0]        o_mux_ctrl2,
  output logic              o_stall,
  output logic              o_bubble,
  output logic              o_flush,
  output logic              o_busy
`ifdef HAZARD_STATS_EN
  ,output logic [31:0]      o_stall_count
`endif
);

  localparam logic [2:0] CNT_RELOAD = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e            state_q;
  logic [2:0]        cnt_q;
  logic              flush_q;

  // Slot index 0 = S1 (EX), 1 = S2 (MEM), 2 = S3 (WB)
  logic [2:0]        slot_vld_q,  slot_vld_d;
  logic [2:0]        slot_ld_q,   slot_ld_d;
  logic [REG_AW-1:0] slot_addr_q [3];
  logic [REG_AW-1:0] slot_addr_d [3];

  logic [2:0]        hit_rs, hit_rt;
  logic              flush_req;
  logic              accept;
  logic              stall;

  function automatic logic src_hit(input logic en, input logic [REG_AW-1:0] src,
                                   input logic vld, input logic [REG_AW-1:0] addr);
    return en && (src != '0) && vld && (addr == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [2:0] hit, input logic s2_load);
    logic [1:0] sel;
    sel = 2'b00;
    if (hit[0])      sel = 2'b00;
    else if (hit[1]) sel = s2_load ? 2'b10 : 2'b01;
    else if (hit[2]) sel = 2'b11;
    return sel;
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      hit_rs[i] = src_hit(i_id_use_rs, i_id_rs, slot_vld_q[i], slot_addr_q[i]);
      hit_rt[i] = src_hit(i_id_use_rt, i_id_rt, slot_vld_q[i], slot_addr_q[i]);
    end
  end

  assign flush_req   = i_exception | i_eret;
  assign accept      = (state_q == ST_IDLE) && flush_req && !i_freeze;
  assign stall       = (hit_rs[0] | hit_rt[0]) & ~flush_q;

  assign o_stall     = stall;
  assign o_bubble    = stall;
  assign o_mux_ctrl1 = fwd_sel(hit_rs, slot_ld_q[1]);
  assign o_mux_ctrl2 = fwd_sel(hit_rt, slot_ld_q[1]);
  assign o_flush     = flush_q;
  assign o_busy      = (state_q == ST_FLUSH);

  // Scoreboard next state: hold on freeze, clear while flushing or on flush entry, else shift.
  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_ld_d  = slot_ld_q;
    for (int i = 0; i < 3; i++) slot_addr_d[i] = slot_addr_q[i];
    if (!i_freeze) begin
      if ((state_q == ST_FLUSH) || accept) begin
        slot_vld_d = 3'b000;
      end else begin
        slot_vld_d[2]  = slot_vld_q[1];
        slot_ld_d[2]   = slot_ld_q[1];
        slot_addr_d[2] = slot_addr_q[1];
        slot_vld_d[1]  = slot_vld_q[0];
        slot_ld_d[1]   = slot_ld_q[0];
        slot_addr_d[1] = slot_addr_q[0];
        slot_vld_d[0]  = !stall && i_id_reg_write && (i_id_wr_addr != '0);
        slot_ld_d[0]   = i_id_mem_read;
        slot_addr_d[0] = i_id_wr_addr;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      slot_vld_q <= 3'b000;
      slot_ld_q  <= 3'b000;
      for (int i = 0; i < 3; i++) slot_addr_q[i] <= '0;
    end else begin
      slot_vld_q <= slot_vld_d;
      slot_ld_q  <= slot_ld_d;
      for (int i = 0; i < 3; i++) slot_addr_q[i] <= slot_addr_d[i];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      flush_q <= 1'b0;
    end else if (!i_freeze) begin
      case (state_q)
        ST_IDLE: begin
          if (flush_req) begin
            state_q <= ST_FLUSH;
            cnt_q   <= CNT_RELOAD;
            flush_q <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (flush_req) begin
            cnt_q <= CNT_RELOAD;
          end else if (cnt_q == 3'd0) begin
            state_q <= ST_IDLE;
            flush_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 3'd0;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_q <= 32'd0;
    end else if (stall && !i_freeze && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_stall_count = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl (FLUSH_CYCLES=2, REG_AW=5).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst, freeze;
  logic [4:0] rs, rt, wr;
  logic       use_rs, use_rt, reg_write, mem_read, exc, eret;
  logic [1:0] mux1, mux2;
  logic       stall, bubble, flush, busy;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  hazard_ctrl #(.FLUSH_CYCLES(2), .REG_AW(5)) dut (
    .i_clk(clk), .i_rst(rst), .i_freeze(freeze),
    .i_id_rs(rs), .i_id_rt(rt), .i_id_use_rs(use_rs), .i_id_use_rt(use_rt),
    .i_id_wr_addr(wr), .i_id_reg_write(reg_write), .i_id_mem_read(mem_read),
    .i_exception(exc), .i_eret(eret),
    .o_mux_ctrl1(mux1), .o_mux_ctrl2(mux2), .o_stall(stall), .o_bubble(bubble),
    .o_flush(flush), .o_busy(busy)
`ifdef HAZARD_STATS_EN
    , .o_stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic [4:0] a_rs, input logic a_urs, input logic [4:0] a_rt,
                     input logic a_urt, input logic [4:0] a_wr, input logic a_rw,
                     input logic a_mr);
    rs = a_rs; use_rs = a_urs; rt = a_rt; use_rt = a_urt;
    wr = a_wr; reg_write = a_rw; mem_read = a_mr;
    exc = 1'b0; eret = 1'b0; freeze = 1'b0;
  endtask

  task automatic idle();
    dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin idle(); nxt(); end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    nxt(); nxt();
    rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_mux1", mux1, 2'b00);  chk("rst_mux2", mux2, 2'b00);
    chk("rst_stall", stall, 1'b0); chk("rst_bubble", bubble, 1'b0);
    chk("rst_flush", flush, 1'b0); chk("rst_busy", busy, 1'b0);
    nxt();

    // ALU chain: add r3 ; sub rs=r3
    dec(5'd0, 0, 5'd0, 0, 5'd3, 1, 0); nxt();
    dec(5'd3, 1, 5'd0, 0, 5'd8, 1, 0); @(negedge clk);
    chk("alu_stall", stall, 1'b1); chk("alu_bubble", bubble, 1'b1); chk("alu_mux1_s1", mux1, 2'b00);
    nxt(); @(negedge clk);
    chk("alu_stall_rel", stall, 1'b0); chk("alu_mux1_fwd", mux1, 2'b01);
    nxt(); drain();

    // load-use: lw r5 ; addi rt=r5
    dec(5'd0, 0, 5'd0, 0, 5'd5, 1, 1); nxt();
    dec(5'd0, 0, 5'd5, 1, 5'd6, 1, 0); @(negedge clk);
    chk("ld_stall", stall, 1'b1); chk("ld_mux2_s1", mux2, 2'b00);
    nxt(); @(negedge clk);
    chk("ld_stall_rel", stall, 1'b0); chk("ld_mux2_mem", mux2, 2'b10);
    nxt(); drain();

    // WB forward of r7, and r0 with an r0 writer in flight
    dec(5'd0, 0, 5'd0, 0, 5'd7, 1, 0); nxt();
    idle(); nxt();
    dec(5'd0, 0, 5'd0, 0, 5'd0, 1, 0); nxt();
    dec(5'd7, 1, 5'd0, 1, 5'd0, 0, 0); @(negedge clk);
    chk("wb_mux1", mux1, 2'b11); chk("r0_mux2", mux2, 2'b00); chk("wb_stall", stall, 1'b0);
    nxt(); drain();

    // priority: r4 in S2 and S3 selects S2
    dec(5'd0, 0, 5'd0, 0, 5'd4, 1, 0); nxt();
    dec(5'd0, 0, 5'd0, 0, 5'd4, 1, 0); nxt();
    idle(); nxt();
    dec(5'd4, 1, 5'd4, 1, 5'd0, 0, 0); @(negedge clk);
    chk("prio_mux1", mux1, 2'b01); chk("prio_mux2", mux2, 2'b01); chk("prio_stall", stall, 1'b0);
    nxt(); drain();

    // freeze holds scoreboard while outputs still evaluate
    dec(5'd0, 0, 5'd0, 0, 5'd3, 1, 0); nxt();
    dec(5'd3, 1, 5'd0, 0, 5'd0, 0, 0); freeze = 1'b1; @(negedge clk);
    chk("frz_stall", stall, 1'b1);
    nxt(); freeze = 1'b0; @(negedge clk);
    chk("frz_stall_held", stall, 1'b1);
    nxt(); @(negedge clk);
    chk("frz_mux1", mux1, 2'b01); chk("frz_stall_rel", stall, 1'b0);
    nxt(); drain();

    // exception with pending stall
    dec(5'd0, 0, 5'd0, 0, 5'd3, 1, 0); nxt();
    dec(5'd3, 1, 5'd0, 0, 5'd0, 0, 0); exc = 1'b1; @(negedge clk);
    chk("exc_stall_same", stall, 1'b1); chk("exc_flush_same", flush, 1'b0);
    nxt(); exc = 1'b0; @(negedge clk);
    chk("exc_flush1", flush, 1'b1); chk("exc_busy1", busy, 1'b1); chk("exc_stall1", stall, 1'b0);
    nxt(); @(negedge clk);
    chk("exc_flush2", flush, 1'b1); chk("exc_stall2", stall, 1'b0);
    nxt(); @(negedge clk);
    chk("exc_flush_end", flush, 1'b0); chk("exc_busy_end", busy, 1'b0);
    chk("exc_mux1_empty", mux1, 2'b00); chk("exc_stall_empty", stall, 1'b0);
    nxt(); drain();

    // exception + eret together: a single 2-cycle flush
    idle(); exc = 1'b1; eret = 1'b1; nxt();
    idle(); @(negedge clk); chk("dual_flush1", flush, 1'b1);
    nxt(); @(negedge clk); chk("dual_flush2", flush, 1'b1);
    nxt(); @(negedge clk); chk("dual_flush_end", flush, 1'b0);
    nxt();

    // eret during FLUSH reloads the counter
    idle(); eret = 1'b1; nxt();
    idle(); eret = 1'b1; @(negedge clk); chk("rl_flush1", flush, 1'b1);
    nxt(); idle(); @(negedge clk); chk("rl_flush2", flush, 1'b1);
    nxt(); @(negedge clk); chk("rl_flush3", flush, 1'b1);
    nxt(); @(negedge clk); chk("rl_flush_end", flush, 1'b0);
    nxt();

    // freeze mid-flush, then reset
    idle(); exc = 1'b1; nxt();
    for (int i = 0; i < 3; i++) begin
      idle(); freeze = 1'b1; @(negedge clk);
      chk($sformatf("frzfl_flush%0d", i), flush, 1'b1);
      chk($sformatf("frzfl_busy%0d", i), busy, 1'b1);
      nxt();
    end
    idle(); rst = 1'b1; nxt();
    rst = 1'b0; @(negedge clk);
    chk("postrst_flush", flush, 1'b0); chk("postrst_busy", busy, 1'b0);
    chk("postrst_stall", stall, 1'b0); chk("postrst_mux1", mux1, 2'b00);
    chk("postrst_mux2", mux2, 2'b00);
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
